// File: rtl/instr_word_packer.sv
// Field-level RV32I encoder for the program-load path: packs I/S/B requests into 32-bit
// words and streams them into instruction memory at an auto-incrementing word address.
module instr_word_packer #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        in_opcode_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [2:0]        in_funct3_i,
  input  logic [31:0]       in_imm_i,
  input  logic              in_last_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrOpcode   = 2'b01;
  localparam logic [1:0] ErrImm      = 2'b10;
  localparam logic [1:0] ErrOverflow = 2'b11;

  // Last slot before the pointer wraps back onto BASE_ADDR.
  localparam logic [ADDR_W-1:0] LastAddr = BASE_ADDR - ADDR_W'(1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;

  logic        imm12_ok, imm13_ok;
  logic        op_ok, imm_ok, legal;
  logic        accept, wr, wrap, finish;
  logic [31:0] word;

  // A value fits a signed N-bit field when all bits from N-1 upward agree.
  assign imm12_ok = (&in_imm_i[31:11]) | ~(|in_imm_i[31:11]);
  assign imm13_ok = ((&in_imm_i[31:12]) | ~(|in_imm_i[31:12])) & ~in_imm_i[0];

  always_comb begin
    op_ok  = 1'b1;
    imm_ok = 1'b1;
    word   = '0;
    case (in_opcode_i)
      OpLoad: begin
        imm_ok = imm12_ok;
        word   = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, in_opcode_i};
      end
      OpStore: begin
        imm_ok = imm12_ok;
        word   = {in_imm_i[11:5], in_rs2_i, in_rs1_i, in_funct3_i, in_imm_i[4:0], in_opcode_i};
      end
      OpBranch: begin
        imm_ok = imm13_ok;
        word   = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, in_funct3_i,
                  in_imm_i[4:1], in_imm_i[11], in_opcode_i};
      end
      default: op_ok = 1'b0;
    endcase
  end

  // start has priority over any request presented in the same cycle.
  assign in_ready_o = (state_q == StRun) & ~start_i;
  assign accept     = in_valid_i & in_ready_o;
  assign legal      = op_ok & imm_ok;
  assign wr         = accept & legal;
  assign wrap       = wr & (ptr_q == LastAddr) & ~in_last_i;
  assign finish     = accept & (in_last_i | wrap);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    if (start_i) begin
      state_d    = StRun;
      ptr_d      = BASE_ADDR;
      count_d    = '0;
      err_d      = 1'b0;
      err_code_d = ErrNone;
      err_addr_d = '0;
    end else if (accept) begin
      if (wr) begin
        ptr_d   = ptr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W + 1)'(1);
      end
      if (!err_q && (!legal || wrap)) begin
        err_d      = 1'b1;
        err_addr_d = ptr_q;
        if (!op_ok)       err_code_d = ErrOpcode;
        else if (!imm_ok) err_code_d = ErrImm;
        else              err_code_d = ErrOverflow;
      end
      if (finish) state_d = StIdle;
    end
  end

  always_comb begin
    mem_we_d    = wr;
    done_d      = finish;
    mem_addr_d  = wr ? ptr_q : mem_addr_q;
    mem_wdata_d = wr ? word : mem_wdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ErrNone;
      err_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign count_o     = count_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_instr_word_packer.sv
// Bench for instr_word_packer: directed encodings and error cases, randomized sessions and an
// overflow session, all compared against a session-level reference model.
module tb_instr_word_packer;

  localparam int unsigned   AW    = 8;
  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] Base  = '0;

  logic          clk, rst_n, start, in_valid, in_ready, in_last;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [31:0]   in_imm;
  logic          mem_we, done, err;
  logic [AW-1:0] mem_addr, err_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic [1:0]    err_code;

  instr_word_packer #(.ADDR_W(AW), .BASE_ADDR(Base)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_opcode_i(in_opcode), .in_rd_i(in_rd), .in_rs1_i(in_rs1),
    .in_rs2_i(in_rs2), .in_funct3_i(in_funct3), .in_imm_i(in_imm), .in_last_i(in_last),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .count_o(count),
    .done_o(done), .err_o(err), .err_code_o(err_code), .err_addr_o(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: session bookkeeping plus expected outputs for the coming cycle.
  bit m_run, m_err, e_we, e_done;
  int m_ptr, m_cnt, m_code, m_eaddr, e_addr;
  logic [31:0] e_wdata;

  function automatic int classify(input int op, input int imm);
    if (op == 'h03 || op == 'h23) return (imm >= -2048 && imm <= 2047) ? 0 : 2;
    if (op == 'h63) return (imm >= -4096 && imm <= 4094 && (imm & 1) == 0) ? 0 : 2;
    return 1;
  endfunction

  function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1,
                                           input int rs2, input int f3, input int imm);
    int w;
    w = (rs1 << 15) | (f3 << 12) | op;
    if (op == 'h03) w = w | ((imm & 'hFFF) << 20) | (rd << 7);
    else if (op == 'h23) w = w | (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | ((imm & 'h1F) << 7);
    else w = w | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20)
               | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7);
    return w;
  endfunction

  task automatic model_reset();
    m_run = 0; m_err = 0; m_ptr = 0; m_cnt = 0; m_code = 0; m_eaddr = 0;
    e_we = 0; e_done = 0; e_addr = 0; e_wdata = '0;
  endtask

  task automatic model_step();
    int cls, op, imm;
    e_we = 0;
    e_done = 0;
    if (start) begin
      m_run = 1; m_ptr = int'(Base); m_cnt = 0; m_err = 0; m_code = 0; m_eaddr = 0;
    end else if (m_run && in_valid) begin
      op  = int'(in_opcode);
      imm = $signed(in_imm);
      cls = classify(op, imm);
      if (cls == 0) begin
        e_we    = 1;
        e_addr  = m_ptr;
        e_wdata = ref_word(op, int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_funct3), imm);
        m_ptr   = (m_ptr + 1) % DEPTH;
        m_cnt++;
        if (in_last) begin
          e_done = 1; m_run = 0;
        end else if (m_cnt == DEPTH) begin
          e_done = 1; m_run = 0;
          if (!m_err) begin m_err = 1; m_code = 3; m_eaddr = e_addr; end
        end
      end else begin
        if (!m_err) begin m_err = 1; m_code = cls; m_eaddr = m_ptr; end
        if (in_last) begin e_done = 1; m_run = 0; end
      end
    end
  endtask

  task automatic compare_all();
    check("ready", 32'(in_ready), 32'(m_run && !start));
    check("we", 32'(mem_we), 32'(e_we));
    if (e_we) begin
      check("addr", 32'(mem_addr), e_addr);
      check("wdata", mem_wdata, e_wdata);
    end
    check("done", 32'(done), 32'(e_done));
    check("count", 32'(count), m_cnt);
    check("err", 32'(err), 32'(m_err));
    check("err_code", 32'(err_code), m_code);
    check("err_addr", 32'(err_addr), m_eaddr);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_req(input int op, input int rd, input int rs1, input int rs2,
                         input int f3, input int imm, input bit last);
    in_valid = 1'b1; in_opcode = 7'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1);
    in_rs2 = 5'(rs2); in_funct3 = 3'(f3); in_imm = imm; in_last = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
  endtask

  task automatic do_start();
    idle_in(); start = 1'b1; cycle(); start = 1'b0;
  endtask

  function automatic int rand_imm();
    int b[10] = '{-2049, -2048, 2047, 2048, -4096, -4097, 4094, 4095, 4096, -4098};
    case ($urandom_range(0, 5))
      0: return int'($urandom_range(0, 4095)) - 2048;
      1: return b[$urandom_range(0, 9)];
      2: return int'($urandom_range(0, 8191)) - 4096;
      3: return int'($urandom());
      default: return (int'($urandom_range(0, 4095)) - 2048) & ~1;
    endcase
  endfunction

  function automatic int rand_op();
    case ($urandom_range(0, 7))
      0, 1, 2: return 'h03;
      3, 4:    return 'h23;
      5, 6:    return 'h63;
      default: return int'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; idle_in(); in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_imm = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    cycle();

    // I-load with last
    do_start();
    set_req('h03, 5, 2, 0, 2, 8, 1); cycle();
    check("t1_wdata", mem_wdata, 32'h00812283);
    check("t1_done", 32'(done), 32'h1);
    idle_in(); cycle();

    // S-store then B-branch back to back
    do_start();
    set_req('h23, 0, 1, 6, 2, -4, 0); cycle();
    check("t2_s_word", mem_wdata, 32'hFE60AE23);
    set_req('h63, 0, 1, 2, 0, -8, 1); cycle();
    check("t2_b_word", mem_wdata, 32'hFE208CE3);
    check("t2_b_addr", 32'(mem_addr), 32'h1);
    check("t2_count", 32'(count), 32'h2);
    idle_in(); cycle();

    // first error wins
    do_start();
    set_req('h03, 1, 1, 0, 0, 4, 0); cycle();
    set_req('h03, 1, 1, 0, 0, 2048, 0); cycle();
    set_req('h63, 0, 1, 2, 0, 3, 0); cycle();
    set_req('h03, 3, 4, 0, 0, -1, 1); cycle();
    idle_in(); cycle();
    check("t3_code", 32'(err_code), 32'h2);
    check("t3_eaddr", 32'(err_addr), 32'h1);
    check("t3_count", 32'(count), 32'h2);

    // unsupported opcode as the only request
    do_start();
    set_req('h33, 1, 2, 3, 0, 0, 1); cycle();
    check("t4_done", 32'(done), 32'h1);
    check("t4_code", 32'(err_code), 32'h1);
    idle_in(); cycle();

    // randomized sessions, occasional restarts
    for (int s = 0; s < 8; s++) begin
      do_start();
      for (int n = 0; n < 60 && m_run; n++) begin
        set_req(rand_op(), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 7), rand_imm(),
                $urandom_range(0, 15) == 0);
        in_valid = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 39) == 0);
        cycle();
        start = 1'b0;
      end
      for (int n = 0; n < 4 && m_run; n++) begin
        set_req('h03, 1, 2, 0, 0, 0, 1); cycle();
      end
      idle_in(); cycle();
    end

    // overflow: capacity + 3 legal non-last requests, the extras must be refused
    do_start();
    for (int n = 0; n < DEPTH + 3; n++) begin
      set_req('h23, 0, $urandom_range(0, 31), $urandom_range(0, 31), 2,
              int'($urandom_range(0, 4095)) - 2048, 0);
      cycle();
    end
    check("ovf_code", 32'(err_code), 32'h3);
    check("ovf_count", 32'(count), 32'(DEPTH));
    check("ovf_ready", 32'(in_ready), 32'h0);
    idle_in(); cycle();

    // async reset during the write cycle of an accepted request
    do_start();
    set_req('h03, 7, 8, 0, 1, 100, 0);
    model_step();
    @(posedge clk);
    #1;
    check("t6_we_before", 32'(mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("t6_wdata", mem_wdata, 32'h0);
    idle_in(); cycle();
    rst_n = 1'b1;
    set_req('h03, 1, 1, 0, 0, 1, 0); cycle();
    cycle();
    idle_in(); cycle();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_word_packer.md
# instr_word_packer

Sequential instruction encoder for the single-cycle RISC-V core's program-load path, the inverse of the immediate decode in the datapath. Accepts field-level instruction descriptions (opcode, registers, funct3, signed immediate) over a valid/ready stream. Packs each into a 32-bit RV32I word for I-type loads, S-type stores and B-type branches, and writes it to instruction memory at an auto-incrementing word address. Range-checks every immediate and reports the first error.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- BASE_ADDR, 0, first word address written after start
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin or restart a load session
- in_valid  in  1  request valid
- in_ready  out  1  block accepts request this cycle
- in_opcode  in  7  opcode; 0000011 I-load, 0100011 S-store, 1100011 B-branch
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_imm  in  32  signed immediate, two's complement
- in_last  in  1  final request of session
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  packed instruction
- count  out  ADDR_W+1  words written this session
- done  out  1  one-cycle session-end pulse
- err  out  1  sticky error flag
- err_code  out  2  01 unsupported opcode, 10 immediate out of range/misaligned, 11 memory overflow
- err_addr  out  ADDR_W  address pointer value when first error occurred

## Operation
- States: IDLE, RUN.
  - IDLE: in_ready=0. start -> RUN; address pointer=BASE_ADDR; count, err, err_code, err_addr cleared.
  - RUN: in_ready=1. Accept on in_valid&in_ready.
  - start in RUN restarts the session (same clearing); any request presented that cycle is ignored (in_ready=0 while start=1).
- Packing:
  - I: {imm[11:0], rs1, funct3, rd, opcode}; legal if -2048 <= imm <= 2047.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; same range.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; legal if -4096 <= imm <= 4094 and imm[0]=0.
  - Unused fields are ignored: rs2 for I; rd for S/B.
- Legal request: word written at pointer; pointer+1; count+1.
- Illegal request (bad opcode or immediate):
  - No write; pointer and count unchanged.
  - If err=0: err=1, err_code set, err_addr=pointer.
  - Later errors do not overwrite the first one (first wins).
- Accepted request with in_last: done pulses, state returns to IDLE. This applies even if that request was illegal.
- Overflow: a legal non-last write to address BASE_ADDR+2^ADDR_W-1 (pointer wraps modulo 2^ADDR_W) ends the session.
  - done pulses, state returns to IDLE.
  - err_code=11 if no earlier error.
- err, err_code, err_addr and count hold in IDLE until the next start.

## Timing
- Reset: state IDLE; in_ready, mem_we, done, err = 0; mem_addr, mem_wdata, count, err_code, err_addr = 0.
- Write path registered: request accepted at edge N -> mem_we=1 with mem_addr/mem_wdata valid during cycle N+1 only.
- Back-to-back accepts give consecutive write cycles; throughput is 1 word/cycle.
- count and err* update at the accepting edge N.
- Session end (in_last accept or overflow) at edge N:
  - done=1 and in_ready=0 during cycle N+1.
  - Final write, if any, is in the same cycle N+1.
- Asynchronous reset mid-session: everything returns to reset values immediately, including an in-flight mem_we. No partial write survives.
- start and in_valid together in IDLE: start wins; the request is not accepted.

## Test plan
- start, then I-load rd=5, rs1=2, funct3=010, imm=8 with in_last -> one write at cycle N+1: addr 0x00, data 0x00812283; done=1 same cycle; count=1; err=0.
- Back-to-back S-store rs2=6, rs1=1, funct3=010, imm=-4, then B-branch rs1=1, rs2=2, funct3=000, imm=-8 with last -> writes 0xFE60AE23 at addr 0 and 0xFE208CE3 at addr 1 on consecutive cycles; count=2.
- Legal I, then I with imm=2048, then B with imm=3, then last legal -> 2 writes at addr 0,1; err=1, err_code=10, err_addr=1 (first error kept).
- Opcode 0110011 as first request with last -> no write, err_code=01, err_addr=0, done pulses.
- ADDR_W=2, four legal requests with no last -> writes to addr 0..3; done after the 4th; err_code=11; in_ready=0; a 5th in_valid is not accepted.
- rst_n low the cycle after an accept -> mem_we does not assert; all outputs 0; state IDLE.
